// File: rtl/io_reset_conditioner.sv
// Board-level input conditioning: synchronizes and debounces the switches and
// reset button, and sequences the CPU reset/enable from the PLL lock signal.
module io_reset_conditioner #(
    parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd50000,
    parameter logic [15:0] RESET_HOLD_CYCLES = 16'd1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw_raw,
    input  logic       btn_raw,
    input  logic       pll_locked,
    output logic [7:0] ui_in,
    output logic       cpu_rst_n,
    output logic       ena,
    output logic [1:0] state
);

    localparam int unsigned NUM_DB    = 9;
    localparam int unsigned SYNC_W    = NUM_DB + 1;
    localparam logic [15:0] DB_LAST   = DEBOUNCE_CYCLES - 16'd1;
    localparam logic [15:0] HOLD_LAST = RESET_HOLD_CYCLES - 16'd1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        HOLD      = 2'b01,
        RUN       = 2'b10
    } fsm_t;

    logic [SYNC_W-1:0] sync_q1;
    logic [SYNC_W-1:0] sync_q2;
    logic              lock_s;
    logic [NUM_DB-1:0] db_in;
    logic [NUM_DB-1:0] db_stable;
    logic              btn_db;

    fsm_t        state_q;
    fsm_t        state_d;
    logic [15:0] hold_q;
    logic [15:0] hold_d;

    // Two-flop synchronizer for every asynchronous board input (lock, button, switches)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {pll_locked, btn_raw, sw_raw};
            sync_q2 <= sync_q1;
        end
    end

    assign lock_s = sync_q2[SYNC_W-1];
    assign db_in  = sync_q2[NUM_DB-1:0];

    // One independent debouncer per synchronized switch/button bit
    for (genvar i = 0; i < NUM_DB; i++) begin : g_db
        logic [15:0] cnt_q;
        logic        stable_q;

        // Count consecutive disagreeing cycles; adopt the new value once the run is long enough
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else if (db_in[i] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                stable_q <= db_in[i];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign db_stable[i] = stable_q;
    end

    assign ui_in  = db_stable[7:0];
    assign btn_db = db_stable[8];

    // Reset sequencer next state: lock loss beats button, button beats hold expiry
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LAST;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                end else if (btn_db) begin
                    hold_d = HOLD_LAST;
                end else if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                end else if (btn_db) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LAST;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                hold_d  = '0;
            end
        endcase
    end

    // Sequencer state plus registered CPU reset/enable decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            hold_q    <= '0;
            ena       <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            ena       <= (state_d != WAIT_LOCK);
            cpu_rst_n <= (state_d == RUN);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_io_reset_conditioner.sv
// Randomized scoreboard bench for io_reset_conditioner (DEBOUNCE=4, HOLD=8).
module tb_io_reset_conditioner;

    localparam int DB = 4;
    localparam int HC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_raw;
    logic       btn_raw;
    logic       pll_locked;
    logic [7:0] ui_in;
    logic       cpu_rst_n;
    logic       ena;
    logic [1:0] state;

    typedef struct packed {
        logic [7:0] ui;
        logic       rst_n;
        logic       en;
        logic [1:0] st;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: synchronizer delay line, sample window, timestamp of last hold start
    logic [9:0] m_s1;
    logic [9:0] m_s2;
    logic [8:0] m_stable;
    logic [8:0] m_hist[$];
    bit         m_active;
    int         m_hold_start;
    int         cyc;

    io_reset_conditioner #(
        .DEBOUNCE_CYCLES  (16'd4),
        .RESET_HOLD_CYCLES(16'd8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .btn_raw   (btn_raw),
        .pll_locked(pll_locked),
        .ui_in     (ui_in),
        .cpu_rst_n (cpu_rst_n),
        .ena       (ena),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic void model_edge(input logic r, input logic [7:0] sw_v,
                                       input logic b_v, input logic l_v);
        obs_t       e;
        logic [1:0] st;
        bit         all_diff;
        if (r) begin
            m_s1     = '0;
            m_s2     = '0;
            m_stable = '0;
            m_hist.delete();
            m_active = 1'b0;
        end else begin
            // FSM decisions use the values visible before this edge
            if (!m_s2[9]) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                m_active     = 1'b1;
                m_hold_start = cyc;
            end else if (m_stable[8]) begin
                m_hold_start = cyc;
            end
            // A bit flips once the last DB samples all disagree with it
            m_hist.push_back(m_s2[8:0]);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            if (m_hist.size() == DB) begin
                for (int k = 0; k < 9; k++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[j]) if (m_hist[j][k] == m_stable[k]) all_diff = 1'b0;
                    if (all_diff) m_stable[k] = ~m_stable[k];
                end
            end
            m_s2 = m_s1;
            m_s1 = {l_v, b_v, sw_v};
        end
        st      = !m_active ? 2'b00 : ((cyc - m_hold_start >= HC) ? 2'b10 : 2'b01);
        e.ui    = m_stable[7:0];
        e.rst_n = (st == 2'b10);
        e.en    = m_active;
        e.st    = st;
        exp_q.push_back(e);
    endfunction

    // Drive one cycle of inputs, then record the expected post-edge outputs
    task automatic step(input logic r, input logic [7:0] sw_v, input logic b_v, input logic l_v);
        rst        = r;
        sw_raw     = sw_v;
        btn_raw    = b_v;
        pll_locked = l_v;
        @(posedge clk);
        cyc++;
        model_edge(r, sw_v, b_v, l_v);
        @(negedge clk);
    endtask

    task automatic hold_inputs(input int n, input logic r, input logic [7:0] sw_v,
                               input logic b_v, input logic l_v);
        for (int i = 0; i < n; i++) step(r, sw_v, b_v, l_v);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation
    initial begin
        obs_t e;
        obs_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {ui_in, cpu_rst_n, ena, state};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t: got ui_in=%h cpu_rst_n=%b ena=%b state=%b, required ui_in=%h cpu_rst_n=%b ena=%b state=%b",
                             $time, got.ui, got.rst_n, got.en, got.st, e.ui, e.rst_n, e.en, e.st);
                end
            end
        end
    end

    initial begin
        logic [7:0] sw_v;
        logic       b_v;
        logic       l_v;
        cyc          = 0;
        m_hold_start = 0;
        m_active     = 1'b0;
        m_s1         = '0;
        m_s2         = '0;
        m_stable     = '0;
        rst = 1'b1; sw_raw = '0; btn_raw = 1'b0; pll_locked = 1'b0;

        // Power-up with lock present right after reset
        hold_inputs(3, 1'b1, 8'h00, 1'b0, 1'b0);
        hold_inputs(20, 1'b0, 8'h00, 1'b0, 1'b1);
        // Clean switch change, return, then a short glitch
        hold_inputs(12, 1'b0, 8'hA5, 1'b0, 1'b1);
        hold_inputs(10, 1'b0, 8'h00, 1'b0, 1'b1);
        hold_inputs(3, 1'b0, 8'hFF, 1'b0, 1'b1);
        hold_inputs(10, 1'b0, 8'h00, 1'b0, 1'b1);
        // Button press in RUN
        hold_inputs(10, 1'b0, 8'h00, 1'b1, 1'b1);
        hold_inputs(20, 1'b0, 8'h00, 1'b0, 1'b1);
        // Lock loss and relock
        hold_inputs(6, 1'b0, 8'h00, 1'b0, 1'b0);
        hold_inputs(20, 1'b0, 8'h00, 1'b0, 1'b1);
        // Lock loss coinciding with hold expiry and debounced button
        hold_inputs(8, 1'b0, 8'h00, 1'b0, 1'b0);
        hold_inputs(4, 1'b0, 8'h00, 1'b0, 1'b1);
        hold_inputs(4, 1'b0, 8'h00, 1'b1, 1'b1);
        hold_inputs(8, 1'b0, 8'h00, 1'b1, 1'b0);
        hold_inputs(8, 1'b0, 8'h00, 1'b0, 1'b0);
        // Reset in the middle of HOLD, then a full HOLD again
        hold_inputs(7, 1'b0, 8'h3C, 1'b0, 1'b1);
        hold_inputs(2, 1'b1, 8'h3C, 1'b0, 1'b1);
        hold_inputs(20, 1'b0, 8'h3C, 1'b0, 1'b1);
        // Reset in the middle of a switch debounce
        hold_inputs(4, 1'b0, 8'h81, 1'b0, 1'b1);
        hold_inputs(1, 1'b1, 8'h81, 1'b0, 1'b1);
        hold_inputs(12, 1'b0, 8'h81, 1'b0, 1'b1);

        // Randomized phase: slow-changing inputs with occasional glitches and resets
        sw_v = 8'h81; b_v = 1'b0; l_v = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11, 0) == 0) sw_v = 8'($urandom);
            if ($urandom_range(19, 0) == 0) b_v = ~b_v;
            if (l_v) begin
                if ($urandom_range(59, 0) == 0) l_v = 1'b0;
            end else if ($urandom_range(7, 0) == 0) begin
                l_v = 1'b1;
            end
            step(($urandom_range(199, 0) == 0), sw_v, b_v, l_v);
        end

        // Let the monitor drain the last expectations
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_reset_conditioner.md
IO_RESET_CONDITIONER -- requirements
Module: io_reset_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, consecutive cycles a synchronized input must differ from its stable value before the output updates (legal range 1..65535).
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 16'd1024, cycles cpu_rst_n is held low after lock or button release (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  single clock, the board clock domain.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sw_raw  input  8  asynchronous board switches.
REQ-006 SHALL have port btn_raw  input  1  asynchronous reset push-button, high = pressed.
REQ-007 SHALL have port pll_locked  input  1  asynchronous clock-wizard lock indication.
REQ-008 SHALL have port ui_in  output  8  debounced switch values for the CPU dedicated inputs.
REQ-009 SHALL have port cpu_rst_n  output  1  active-low CPU reset.
REQ-010 SHALL have port ena  output  1  design-enable to the CPU.
REQ-011 SHALL have port state  output  2  debug copy of FSM state (00 WAIT_LOCK, 01 HOLD, 10 RUN).

Function
REQ-012 SHALL pass sw_raw, btn_raw, pll_locked each through a 2-flop synchronizer; no other logic reads the raw inputs.
REQ-013 SHALL debounce each of the 9 synchronized bits (8 switches + button) with an independent 16-bit counter and a stable-value register.
REQ-014 Per bit, when synchronized value equals stable value the counter SHALL clear to 0; otherwise it SHALL increment.
REQ-015 Per bit, when the counter reaches DEBOUNCE_CYCLES-1 while values still differ, the stable value SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-016 A clean raw transition SHALL appear on ui_in exactly DEBOUNCE_CYCLES+2 clk edges after the raw change; a glitch of fewer than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-017 FSM SHALL have states WAIT_LOCK, HOLD, RUN, with a 16-bit hold counter.
REQ-018 WAIT_LOCK: cpu_rst_n=0, ena=0; on synchronized lock=1 go to HOLD and load hold counter with RESET_HOLD_CYCLES-1.
REQ-019 HOLD: cpu_rst_n=0, ena=1; decrement counter each cycle; when counter=0 go to RUN.
REQ-020 RUN: cpu_rst_n=1, ena=1; remain until lock loss or button press.
REQ-021 Debounced button=1 in HOLD or RUN SHALL go/stay in HOLD and reload the counter; a held button keeps HOLD indefinitely.
REQ-022 Synchronized lock=0 in any state SHALL go to WAIT_LOCK on the next edge.
REQ-023 Priority when events coincide SHALL be: lock loss > button > counter expiry.
REQ-024 cpu_rst_n, ena, state, ui_in SHALL all be registered outputs; cpu_rst_n deasserts on the first edge where state becomes RUN, i.e. exactly RESET_HOLD_CYCLES cycles after entering HOLD.
REQ-025 Debounce operation SHALL be independent of FSM state, including during WAIT_LOCK.

Reset
REQ-026 rst=1 at a clk edge SHALL clear all synchronizer flops, stable values (ui_in=8'h00, button=0), and all counters, and force state=WAIT_LOCK, cpu_rst_n=0, ena=0.
REQ-027 rst asserted mid-HOLD or mid-debounce SHALL abandon that operation with no residual count after release.
REQ-028 After rst deasserts, outputs SHALL remain at reset values until the synchronized inputs drive a transition as specified.

Verification (DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8)
REQ-029 Power-up: rst 3 cycles, pll_locked=1 at cycle 0 after rst -> ena=1 at edge 3, cpu_rst_n=1 at edge 11, state 00->01->10.
REQ-030 Switch: sw_raw 00->A5 held -> ui_in=A5 exactly 6 edges later; 3-cycle pulse 00->FF->00 -> ui_in stays 00.
REQ-031 Button in RUN: btn_raw high 10 cycles -> cpu_rst_n=0 from edge 7 after press, ena stays 1, cpu_rst_n=1 again 8 cycles after debounced release.
REQ-032 Lock loss in RUN: pll_locked 1->0 -> state=00, ena=0, cpu_rst_n=0 within 3 edges; relock -> full 8-cycle HOLD again.
REQ-033 Coincidence: lock loss on the same edge as hold expiry and button press -> WAIT_LOCK, cpu_rst_n never pulses high.
REQ-034 rst asserted in HOLD with count 3 remaining -> WAIT_LOCK, ui_in=00; on release with lock high, HOLD lasts a full 8 cycles.
